// File: rtl/sky130_gpio_pkg.sv
// Shared definitions for the Sky130 GPIO pad-controller bank: mode codes,
// channel FSM states, the SAFE (hi-z) pad values and mode helper functions.
package sky130_gpio_pkg;

    localparam logic [2:0] MODE_ANALOG   = 3'd0;
    localparam logic [2:0] MODE_INPUT    = 3'd1;
    localparam logic [2:0] MODE_INPUT_PD = 3'd2;
    localparam logic [2:0] MODE_INPUT_PU = 3'd3;
    localparam logic [2:0] MODE_OUTPUT   = 3'd4;
    localparam logic [2:0] MODE_BIDIR    = 3'd5;

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_SAFE   = 1'b1
    } chan_state_e;

    // Pad values held while a channel sits in SAFE between drive modes.
    localparam logic [2:0] SAFE_DM      = 3'b001;
    localparam logic       SAFE_INP_DIS = 1'b0;
    localparam logic       SAFE_OEB     = 1'b1;
    localparam logic       SAFE_OUT     = 1'b0;
    localparam logic       SAFE_ANALOG  = 1'b0;

    function automatic logic [2:0] mode_to_dm(input logic [2:0] mode);
        logic [2:0] dm;
        case (mode)
            MODE_ANALOG:   dm = 3'b000;
            MODE_INPUT:    dm = 3'b001;
            MODE_INPUT_PD: dm = 3'b011;
            MODE_INPUT_PU: dm = 3'b010;
            MODE_OUTPUT:   dm = 3'b110;
            MODE_BIDIR:    dm = 3'b110;
            default:       dm = 3'b001;
        endcase
        return dm;
    endfunction

    // Unused codes 6/7 fall back to plain INPUT, the safest receive mode.
    function automatic logic [2:0] mode_sanitize(input logic [2:0] code);
        return (code > MODE_BIDIR) ? MODE_INPUT : code;
    endfunction

endpackage

// File: rtl/sky130_gpio_chan.sv
// One GPIO pad-controller channel: ACTIVE/SAFE FSM with settle down-counter,
// pad-config decode and, with SKY130_GPIO_BANK_IRQ_EN defined, edge IRQ logic.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_ACTIVE | pad driven from the committed mode
// ST_SAFE   | pad held hi-z/input while the counter runs; pending mode held
module sky130_gpio_chan
    import sky130_gpio_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_we,
    input  logic [2:0] i_wdata,
    input  logic       i_io_out,
    input  logic       i_io_oeb,
    input  logic       i_an_sel,
    input  logic       i_an_pol,
    input  logic       i_pad_in,
    input  logic       i_rise_en,
    input  logic       i_fall_en,
    input  logic       i_irq_clr,
    output logic [2:0] o_mode,
    output logic       o_busy,
    output logic [2:0] o_dm,
    output logic       o_inp_dis,
    output logic       o_oeb,
    output logic       o_out,
    output logic       o_analog_en,
    output logic       o_analog_sel,
    output logic       o_analog_pol,
    output logic       o_irq_status,
    output logic       o_irq_nxt
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    chan_state_e r_state, w_state_nxt;
    logic [2:0]    r_mode, w_mode_nxt;
    logic [2:0]    r_pend, w_pend_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    w_wmode;
    logic [2:0]    r_dm;
    logic          r_inp_dis;
    logic          r_analog_en;

    // Next-state: mode writes enter/restart SAFE, counter expiry commits.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_pend_nxt  = r_pend;
        w_cnt_nxt   = r_cnt;
        w_wmode     = mode_sanitize(i_wdata);
        case (r_state)
            ST_ACTIVE: begin
                if (i_we && (w_wmode != r_mode)) begin
                    w_state_nxt = ST_SAFE;
                    w_pend_nxt  = w_wmode;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            ST_SAFE: begin
                if (i_we) begin
                    w_pend_nxt = w_wmode;
                    w_cnt_nxt  = CNT_LOAD;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_ACTIVE;
                    w_mode_nxt  = r_pend;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: w_state_nxt = ST_ACTIVE;
        endcase
    end

    // State, mode, counter and the glitch-sensitive pad controls, all registered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_ACTIVE;
            r_mode      <= MODE_INPUT;
            r_pend      <= MODE_INPUT;
            r_cnt       <= '0;
            r_dm        <= mode_to_dm(MODE_INPUT);
            r_inp_dis   <= 1'b0;
            r_analog_en <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_pend  <= w_pend_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_state_nxt == ST_SAFE) begin
                r_dm        <= SAFE_DM;
                r_inp_dis   <= SAFE_INP_DIS;
                r_analog_en <= SAFE_ANALOG;
            end else begin
                r_dm        <= mode_to_dm(w_mode_nxt);
                r_inp_dis   <= (w_mode_nxt == MODE_ANALOG) || (w_mode_nxt == MODE_OUTPUT);
                r_analog_en <= (w_mode_nxt == MODE_ANALOG);
            end
        end
    end

    // User data paths pass through combinationally, gated by registered mode.
    always_comb begin
        o_oeb        = SAFE_OEB;
        o_out        = SAFE_OUT;
        o_analog_sel = SAFE_ANALOG;
        o_analog_pol = SAFE_ANALOG;
        if (r_state == ST_ACTIVE) begin
            case (r_mode)
                MODE_ANALOG: begin
                    o_analog_sel = i_an_sel;
                    o_analog_pol = i_an_pol;
                end
                MODE_INPUT_PD: o_oeb = 1'b0;
                MODE_INPUT_PU: begin
                    o_oeb = 1'b0;
                    o_out = 1'b1;
                end
                MODE_OUTPUT: begin
                    o_oeb = 1'b0;
                    o_out = i_io_out;
                end
                MODE_BIDIR: begin
                    o_oeb = i_io_oeb;
                    o_out = i_io_out;
                end
                default: ;
            endcase
        end
    end

    assign o_mode      = r_mode;
    assign o_busy      = (r_state == ST_SAFE);
    assign o_dm        = r_dm;
    assign o_inp_dis   = r_inp_dis;
    assign o_analog_en = r_analog_en;

`ifdef SKY130_GPIO_BANK_IRQ_EN
    logic r_sync1, r_sync2, r_sync3;
    logic r_irq;
    logic w_armed, w_set;

    // Two-flop synchronizer plus a history flop for edge detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= i_pad_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_armed = (r_state == ST_ACTIVE) &&
                     ((r_mode == MODE_INPUT) || (r_mode == MODE_INPUT_PD) ||
                      (r_mode == MODE_INPUT_PU) || (r_mode == MODE_BIDIR));
    assign w_set = w_armed && ((i_rise_en && r_sync2 && !r_sync3) ||
                               (i_fall_en && !r_sync2 && r_sync3));
    // A new edge beats a simultaneous clear so no event is lost.
    assign o_irq_nxt = w_set | (r_irq & ~i_irq_clr);

    // Sticky flag; SAFE entry leaves it untouched.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_irq <= 1'b0;
        else       r_irq <= o_irq_nxt;
    end

    assign o_irq_status = r_irq;
`else
    logic w_unused_irq;
    assign w_unused_irq = ^{i_pad_in, i_rise_en, i_fall_en, i_irq_clr};
    assign o_irq_status = 1'b0;
    assign o_irq_nxt    = 1'b0;
`endif

endmodule

// File: rtl/sky130_gpio_bank.sv
// Runtime-programmable bank of N_GPIO Sky130 Openframe pad controllers.
// Address-decodes mode writes to channels and packs per-pad config vectors.
// Define SKY130_GPIO_BANK_IRQ_EN to build the edge-interrupt logic.
module sky130_gpio_bank
    import sky130_gpio_pkg::*;
#(
    parameter int N_GPIO        = 8,
    parameter int SETTLE_CYCLES = 4,
    localparam int AW           = (N_GPIO > 1) ? $clog2(N_GPIO) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [2:0]            cfg_wdata,
    output logic [3*N_GPIO-1:0]   mode_status,
    output logic [N_GPIO-1:0]     busy,
    input  logic [N_GPIO-1:0]     io_out,
    input  logic [N_GPIO-1:0]     io_oeb,
    input  logic [2*N_GPIO-1:0]   analog,
    output logic [N_GPIO-1:0]     io_in,
    input  logic [N_GPIO-1:0]     gpio_in,
    output logic [3*N_GPIO-1:0]   gpio_dm,
    output logic [N_GPIO-1:0]     gpio_inp_dis,
    output logic [N_GPIO-1:0]     gpio_oeb,
    output logic [N_GPIO-1:0]     gpio_out,
    output logic [N_GPIO-1:0]     gpio_analog_en,
    output logic [N_GPIO-1:0]     gpio_analog_sel,
    output logic [N_GPIO-1:0]     gpio_analog_pol,
    output logic [N_GPIO-1:0]     gpio_ib_mode_sel,
    output logic [N_GPIO-1:0]     gpio_vtrip_sel,
    output logic [N_GPIO-1:0]     gpio_slow_sel,
    output logic [N_GPIO-1:0]     gpio_holdover,
    input  logic [N_GPIO-1:0]     irq_rise_en,
    input  logic [N_GPIO-1:0]     irq_fall_en,
    input  logic [N_GPIO-1:0]     irq_clr,
    output logic [N_GPIO-1:0]     irq_status,
    output logic                  irq
);

    logic [N_GPIO-1:0] w_irq_nxt;

    for (genvar g = 0; g < N_GPIO; g++) begin : g_chan
        localparam logic [AW-1:0] L_ADDR = AW'(g);
        logic w_we;
        // Out-of-range addresses match no channel and are dropped here.
        assign w_we = cfg_we && (cfg_addr == L_ADDR);

        sky130_gpio_chan #(
            .SETTLE_CYCLES (SETTLE_CYCLES)
        ) u_chan (
            .i_clk        (clk),
            .i_rst        (rst),
            .i_we         (w_we),
            .i_wdata      (cfg_wdata),
            .i_io_out     (io_out[g]),
            .i_io_oeb     (io_oeb[g]),
            .i_an_sel     (analog[2*g+1]),
            .i_an_pol     (analog[2*g]),
            .i_pad_in     (gpio_in[g]),
            .i_rise_en    (irq_rise_en[g]),
            .i_fall_en    (irq_fall_en[g]),
            .i_irq_clr    (irq_clr[g]),
            .o_mode       (mode_status[3*g +: 3]),
            .o_busy       (busy[g]),
            .o_dm         (gpio_dm[3*g +: 3]),
            .o_inp_dis    (gpio_inp_dis[g]),
            .o_oeb        (gpio_oeb[g]),
            .o_out        (gpio_out[g]),
            .o_analog_en  (gpio_analog_en[g]),
            .o_analog_sel (gpio_analog_sel[g]),
            .o_analog_pol (gpio_analog_pol[g]),
            .o_irq_status (irq_status[g]),
            .o_irq_nxt    (w_irq_nxt[g])
        );
    end

    assign io_in            = gpio_in;
    assign gpio_ib_mode_sel = '0;
    assign gpio_vtrip_sel   = '0;
    assign gpio_slow_sel    = '0;
    assign gpio_holdover    = '0;

`ifdef SKY130_GPIO_BANK_IRQ_EN
    logic r_irq;

    // Registered OR taken from the flags' next values so irq lines up with irq_status.
    always_ff @(posedge clk) begin
        if (rst) r_irq <= 1'b0;
        else     r_irq <= |w_irq_nxt;
    end

    assign irq = r_irq;
`else
    logic w_unused_irq;
    assign w_unused_irq = |w_irq_nxt;
    assign irq = 1'b0;
`endif

endmodule

// File: doc/sky130_gpio_bank.md
# sky130_gpio_bank

Runtime-programmable bank of Sky130 Openframe GPIO pad controllers. Each of `N_GPIO` channels holds a pad mode written through a simple config port. Mode changes are sequenced through a safe hi-z state so a pad never glitches between drive modes. Sits between user logic and the `openframe_project_wrapper` pad-config vectors, replacing fixed compile-time per-pad configuration.

## Interface
Parameters:
- `N_GPIO`, 8: channel count (1..44).
- `SETTLE_CYCLES`, 4: cycles a channel spends in SAFE on a mode change (>=1).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  bank clock.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_we`  in  1  mode write strobe.
- `cfg_addr`  in  `$clog2(N_GPIO)`  target channel.
- `cfg_wdata`  in  3  mode: 0 ANALOG, 1 INPUT, 2 INPUT_PD, 3 INPUT_PU, 4 OUTPUT, 5 BIDIR.
- `mode_status`  out  3*N_GPIO  effective mode per channel.
- `busy`  out  N_GPIO  channel in SAFE.
- `io_out`, `io_oeb`  in  N_GPIO each  user data / output-enable-bar (BIDIR).
- `analog`  in  2*N_GPIO  {sel,pol} per channel.
- `io_in`  out  N_GPIO  = `gpio_in`, combinational.
- `gpio_in`  in  N_GPIO  pad inputs.
- `gpio_dm`  out  3*N_GPIO.
- `gpio_inp_dis`, `gpio_oeb`, `gpio_out`, `gpio_analog_en`, `gpio_analog_sel`, `gpio_analog_pol`, `gpio_ib_mode_sel`, `gpio_vtrip_sel`, `gpio_slow_sel`, `gpio_holdover`  out  N_GPIO each.
- `irq_rise_en`, `irq_fall_en`, `irq_clr`  in  N_GPIO each  edge enables, write-1-to-clear.
- `irq_status`  out  N_GPIO  sticky flags.
- `irq`  out  1  OR of `irq_status`.

## Operation
- Per-channel FSM with two states.
  - ACTIVE: pad outputs decode the stored mode.
  - SAFE: dm=001, inp_dis=0, oeb=1, out=0, analog_en/sel/pol=0.
- Per-mode decode:
  - ANALOG: dm 000, inp_dis 1, oeb 1, analog_en 1, sel/pol from `analog`.
  - INPUT: dm 001, oeb 1.
  - INPUT_PD: dm 011, oeb 0, out 0.
  - INPUT_PU: dm 010, oeb 0, out 1.
  - OUTPUT: dm 110, inp_dis 1, oeb 0, out=`io_out`.
  - BIDIR: dm 110, oeb=`io_oeb`, out=`io_out`.
- `ib_mode_sel`, `vtrip_sel`, `slow_sel` and `holdover` are constant 0.
- Mode write rules:
  - ACTIVE, `cfg_wdata` differs from the stored mode: load pending mode, counter=SETTLE_CYCLES-1, go to SAFE.
  - ACTIVE, same mode: ignored.
  - SAFE, any write: reload pending mode and restart the counter.
  - SAFE, counter==0: commit pending mode, go to ACTIVE.
  - Codes 6 and 7 are stored as INPUT (1).
  - `cfg_addr` >= N_GPIO: write ignored.
- `mode_status` shows the committed mode; it updates on the same edge as the ACTIVE entry.
- Reset: all channels ACTIVE in INPUT.
  - Outputs after reset: dm=001, oeb=1, out=0, inp_dis=0, analog_* 0, `busy`=0, `irq_status`=0, `irq`=0.
  - Reset mid-SAFE abandons the pending mode.

## Timing
- `cfg_we` sampled at edge t: `busy`=1 and SAFE outputs from t+1 for SETTLE_CYCLES cycles; new mode outputs from t+1+SETTLE_CYCLES.
- dm, inp_dis and analog_en are driven from registered state (glitch-free).
- `gpio_out`/`gpio_oeb` follow `io_out`/`io_oeb` combinationally in OUTPUT/BIDIR, gated by the registered mode.
- One write per cycle. Writes to different channels on consecutive cycles are independent.

## Configuration
- `SKY130_GPIO_BANK_IRQ_EN` defined:
  - 2-flop synchronizer on `gpio_in`, plus a third flop for edge detect.
  - An `irq_status` bit sets on an enabled rise/fall while the channel is ACTIVE in INPUT, INPUT_PD, INPUT_PU or BIDIR.
  - `irq_clr` clears; set wins over a simultaneous clear.
  - `irq` is registered OR.
  - Latency: pad edge to `irq_status` is 3 cycles.
  - Entering SAFE does not clear existing flags.
- Undefined: no IRQ flops; `irq_status`=0, `irq`=0, IRQ inputs ignored. Ports remain.

## Structure
- Package `sky130_gpio_pkg` holds:
  - mode localparams/enum (`MODE_ANALOG`..`MODE_BIDIR`);
  - `mode_to_dm` function;
  - SAFE-state constant values.
- Sub-module `sky130_gpio_chan` (FSM, counter, decode, optional IRQ) is instantiated N_GPIO times by generate.
- Top level does address decode and vector packing.

## Test plan
- Reset, then check a channel's outputs: dm=001, oeb=1, `busy`=0, `mode_status`=1.
- Write ch2 OUTPUT at t with `io_out`=1.
  - t+1..t+4: `busy[2]`=1, oeb=1.
  - t+5: dm=110, oeb=0, out=1.
- Write ch0 INPUT_PU, then rewrite INPUT_PD at t+2: `busy` stays high until t+2+5; final dm=011, out=0.
- Write mode 7 to ch1 and `cfg_addr`=N_GPIO: ch1 ends INPUT with no SAFE entry (already INPUT); the out-of-range write changes nothing.
- IRQ_EN, ch3 INPUT with `irq_rise_en[3]`=1, `gpio_in[3]` 0→1 at t: `irq_status[3]`=1 at t+3, `irq`=1; `irq_clr` asserted on the same cycle as a new edge leaves the flag set.
- `rst` asserted mid-SAFE: next cycle channel is INPUT, `busy`=0, pending mode lost.
